fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 64-bit RISC-V pipeline. It owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. It consumes the branch decision produced by the EX-stage branch unit, redirecting the PC to the branch target and squashing wrong-path instructions. It also keeps saturating branch statistics for debug.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned
- NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) placed in IF/ID on flush or reset
- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit hold request; freezes the PC and IF/ID
- is_branch  in  1  EX stage holds a conditional branch this cycle; one-cycle pulse per branch
- branch_taken  in  1  branch-unit decision, 1 = take; meaningful only when is_branch=1
- branch_target  in  64  computed target address from EX
- imem_addr  out  64  instruction-memory address, equal to the current PC, combinational
- imem_rdata  in  32  instruction word at imem_addr, returned in the same cycle (combinational memory)
- ifid_pc  out  64  PC of the instruction held in IF/ID
- ifid_instr  out  32  instruction held in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction, not a bubble
- flush  out  1  combinational; squash the instruction currently in ID (ID/EX loads a bubble)
- misalign_err  out  1  sticky; a taken branch targeted an address with target[1:0]≠0
- branch_count  out  32  number of is_branch cycles seen, saturating
- taken_count  out  32  number of taken branches, saturating

## Operation
- redirect = is_branch & branch_taken. flush = redirect, combinational, with no dependence on stall.
- Priority on each rising edge is reset, then redirect, then stall, then normal advance.
- Reset:
  - pc <= RESET_PC.
  - ifid_pc <= 0, ifid_instr <= NOP_INSTR, ifid_valid <= 0.
  - misalign_err <= 0, branch_count <= 0, taken_count <= 0.
- Redirect (overrides stall):
  - pc <= {branch_target[63:2], 2'b00}.
  - IF/ID loads a bubble: ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc <= 0.
  - If branch_target[1:0]≠0, misalign_err <= 1. The bit stays set until reset.
- Stall without redirect: pc and all IF/ID fields hold their values. The word on imem_rdata is discarded.
- Normal advance:
  - pc <= pc + 4, modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - ifid_pc <= pc, ifid_instr <= imem_rdata, ifid_valid <= 1.
- Counters update independently of stall:
  - branch_count increments on every cycle with is_branch=1.
  - taken_count increments on every cycle with redirect=1.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- is_branch=0 with branch_taken=1: no redirect, no count change.

## Timing
- All registered outputs change only on rising edges of clk. imem_addr and flush are combinational.
- Fetch latency: the word presented on imem_rdata in cycle N appears on ifid_instr in cycle N+1.
- Branch penalty: two bubbles.
  - A taken branch resolved in EX in cycle N asserts flush in N, which squashes the instruction in ID.
  - The IF/ID register is a bubble in N+1.
  - imem_addr = target in N+1.
  - The target instruction is valid in IF/ID in N+2.
- Not-taken branch: no bubbles, and the sequential stream continues.
- Back-to-back redirects in N and N+1: the second redirect wins. IF/ID stays a bubble through N+2, and the PC holds the second target in N+2.
- Reset asserted mid-redirect or mid-stall: reset wins, and all state returns to reset values on that edge.
- First cycle after reset deasserts: imem_addr = RESET_PC, ifid_valid=0. The first valid IF/ID entry appears one cycle later.

## Test plan
- Reset with RESET_PC=64'h1000, then 3 free-running cycles with imem_rdata = A, B, C:
  - imem_addr steps through 1000, 1004, 1008, 100C.
  - ifid_instr/ifid_pc go to A/1000, B/1004, C/1008, each with ifid_valid=1.
- Stall held 2 cycles at pc=1008:
  - imem_addr stays 1008 and IF/ID stays B/1004.
  - After release, C/1008 loads on the next edge.
- Taken branch (is_branch=1, branch_taken=1, target=64'h2000) while stall=1:
  - flush=1 in the same cycle.
  - Next cycle: imem_addr=2000, ifid_valid=0, ifid_instr=0x00000013.
  - The cycle after: ifid_pc=2000, ifid_valid=1.
  - branch_count=1, taken_count=1.
- Not-taken branch at pc=1010: flush=0, PC advances to 1014, branch_count increments, taken_count is unchanged.
- Taken branch with target=64'h2002:
  - The PC loads 2000 and misalign_err=1.
  - misalign_err stays 1 across further branches and clears only on reset.
- Counter saturation and PC wrap:
  - With taken_count preloaded (force) to FFFF_FFFF, another taken branch leaves it at FFFF_FFFF.
  - A PC at FFFF_FFFF_FFFF_FFFC advances to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, and
// registers the fetched word into IF/ID. Taken branches from EX redirect the
// PC and squash wrong-path work. Saturating branch statistics are kept for debug.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        flush,
    output logic        misalign_err,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    logic        redirect;
    logic [63:0] pc_q, pc_d;
    logic [63:0] ifidPc_q, ifidPc_d;
    logic [31:0] ifidInstr_q, ifidInstr_d;
    logic        ifidValid_q, ifidValid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] branchCount_q, branchCount_d;
    logic [31:0] takenCount_q, takenCount_d;

    assign redirect = is_branch & branch_taken;

    // Next-state selection: redirect beats stall, stall beats normal advance;
    // counters move regardless of stall and stick at all-ones.
    always_comb begin
        pc_d          = pc_q;
        ifidPc_d      = ifidPc_q;
        ifidInstr_d   = ifidInstr_q;
        ifidValid_d   = ifidValid_q;
        misalign_d    = misalign_q;
        branchCount_d = branchCount_q;
        takenCount_d  = takenCount_q;

        if (redirect) begin
            pc_d        = {branch_target[63:2], 2'b00};
            ifidPc_d    = 64'h0;
            ifidInstr_d = NOP_INSTR;
            ifidValid_d = 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d        = pc_q + 64'd4;
            ifidPc_d    = pc_q;
            ifidInstr_d = imem_rdata;
            ifidValid_d = 1'b1;
        end

        if (is_branch && (branchCount_q != 32'hFFFF_FFFF)) begin
            branchCount_d = branchCount_q + 32'd1;
        end
        if (redirect && (takenCount_q != 32'hFFFF_FFFF)) begin
            takenCount_d = takenCount_q + 32'd1;
        end
    end

    // State registers with synchronous reset that overrides every other request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ifidPc_q      <= 64'h0;
            ifidInstr_q   <= NOP_INSTR;
            ifidValid_q   <= 1'b0;
            misalign_q    <= 1'b0;
            branchCount_q <= 32'h0;
            takenCount_q  <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            ifidPc_q      <= ifidPc_d;
            ifidInstr_q   <= ifidInstr_d;
            ifidValid_q   <= ifidValid_d;
            misalign_q    <= misalign_d;
            branchCount_q <= branchCount_d;
            takenCount_q  <= takenCount_d;
        end
    end

    assign imem_addr    = pc_q;
    assign flush        = redirect;
    assign ifid_pc      = ifidPc_q;
    assign ifid_instr   = ifidInstr_q;
    assign ifid_valid   = ifidValid_q;
    assign misalign_err = misalign_q;
    assign branch_count = branchCount_q;
    assign taken_count  = takenCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected IF/ID contents are queued as
// stimulus is driven and compared once the stage has registered them.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        flush;
    logic        misalign_err;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    int checks = 0;
    int errors = 0;
    ifid_t sb[$];
    logic [31:0] words [4];

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .is_branch(is_branch),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .flush(flush),
        .misalign_err(misalign_err), .branch_count(branch_count),
        .taken_count(taken_count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stall = 1'b1; is_branch = 1'b1; branch_taken = 1'b1; branch_target = 64'h7777;
        do_reset();
        stall = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        #1;
        checks++;
        if (imem_addr !== RST_PC || ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: addr=%h valid=%b instr=%h pc=%h, want %h 0 %h 0",
                     imem_addr, ifid_valid, ifid_instr, ifid_pc, RST_PC, NOP);
        end
        checks++;
        if (branch_count !== 32'h0 || taken_count !== 32'h0 || misalign_err !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stats: bc=%h tc=%h mis=%b flush=%b, want 0 0 0 0",
                     branch_count, taken_count, misalign_err, flush);
        end
    endtask

    task automatic test_fetch();
        ifid_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            imem_rdata = words[i];
            #1;
            checks++;
            if (imem_addr !== RST_PC + 64'(4 * i)) begin
                errors++;
                $display("[TB] FAIL fetch_addr%0d: got %h want %h", i, imem_addr, RST_PC + 64'(4 * i));
            end
            sb.push_back('{pc: RST_PC + 64'(4 * i), instr: words[i], valid: 1'b1});
            tick();
            e = sb.pop_front();
            checks++;
            if (ifid_pc !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid) begin
                errors++;
                $display("[TB] FAIL fetch_ifid%0d: got %h/%h/%b want %h/%h/%b",
                         i, ifid_pc, ifid_instr, ifid_valid, e.pc, e.instr, e.valid);
            end
        end
        checks++;
        if (imem_addr !== RST_PC + 64'hC) begin
            errors++;
            $display("[TB] FAIL fetch_addr_end: got %h want %h", imem_addr, RST_PC + 64'hC);
        end
    endtask

    task automatic test_stall();
        ifid_t e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            imem_rdata = words[i];
            tick();
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            imem_rdata = 32'hDEAD_0000 + 32'(i);
            tick();
            checks++;
            if (imem_addr !== RST_PC + 64'h8 || ifid_pc !== RST_PC + 64'h4 || ifid_instr !== words[1] || ifid_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: addr=%h ifid=%h/%h/%b want %h %h/%h/1",
                         i, imem_addr, ifid_pc, ifid_instr, ifid_valid, RST_PC + 64'h8, RST_PC + 64'h4, words[1]);
            end
        end
        stall = 1'b0;
        imem_rdata = words[2];
        sb.push_back('{pc: RST_PC + 64'h8, instr: words[2], valid: 1'b1});
        tick();
        e = sb.pop_front();
        checks++;
        if (ifid_pc !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid) begin
            errors++;
            $display("[TB] FAIL stall_release: got %h/%h/%b want %h/%h/%b",
                     ifid_pc, ifid_instr, ifid_valid, e.pc, e.instr, e.valid);
        end
    endtask

    task automatic test_taken_branch();
        ifid_t e;
        stall = 1'b1; is_branch = 1'b1; branch_taken = 1'b1; branch_target = 64'h2000;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL taken_flush: got %b want 1", flush);
        end
        sb.push_back('{pc: 64'h0, instr: NOP, valid: 1'b0});
        tick();
        stall = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        e = sb.pop_front();
        checks++;
        if (imem_addr !== 64'h2000 || ifid_pc !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid) begin
            errors++;
            $display("[TB] FAIL taken_bubble: addr=%h ifid=%h/%h/%b want 2000 %h/%h/%b",
                     imem_addr, ifid_pc, ifid_instr, ifid_valid, e.pc, e.instr, e.valid);
        end
        imem_rdata = words[3];
        sb.push_back('{pc: 64'h2000, instr: words[3], valid: 1'b1});
        tick();
        e = sb.pop_front();
        checks++;
        if (ifid_pc !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid) begin
            errors++;
            $display("[TB] FAIL taken_target: got %h/%h/%b want %h/%h/%b",
                     ifid_pc, ifid_instr, ifid_valid, e.pc, e.instr, e.valid);
        end
        checks++;
        if (branch_count !== 32'd1 || taken_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL taken_counts: bc=%0d tc=%0d want 1 1", branch_count, taken_count);
        end
    endtask

    task automatic test_not_taken();
        logic [63:0] pcBefore;
        pcBefore = imem_addr;
        is_branch = 1'b1; branch_taken = 1'b0; branch_target = 64'h3000;
        #1;
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nt_flush: got %b want 0", flush);
        end
        tick();
        is_branch = 1'b0; branch_taken = 1'b1;
        checks++;
        if (imem_addr !== pcBefore + 64'd4 || ifid_valid !== 1'b1 || branch_count !== 32'd2 || taken_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL nt_advance: addr=%h valid=%b bc=%0d tc=%0d want %h 1 2 1",
                     imem_addr, ifid_valid, branch_count, taken_count, pcBefore + 64'd4);
        end
        #1;
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_taken_flush: got %b want 0", flush);
        end
        tick();
        branch_taken = 1'b0;
        checks++;
        if (imem_addr !== pcBefore + 64'd8 || branch_count !== 32'd2 || taken_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL stray_taken: addr=%h bc=%0d tc=%0d want %h 2 1",
                     imem_addr, branch_count, taken_count, pcBefore + 64'd8);
        end
    endtask

    task automatic test_misalign();
        is_branch = 1'b1; branch_taken = 1'b1; branch_target = 64'h2002;
        tick();
        checks++;
        if (imem_addr !== 64'h2000 || misalign_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_set: addr=%h mis=%b want 2000 1", imem_addr, misalign_err);
        end
        branch_target = 64'h3000;
        tick();
        is_branch = 1'b0; branch_taken = 1'b0;
        tick();
        checks++;
        if (misalign_err !== 1'b1 || imem_addr !== 64'h3004) begin
            errors++;
            $display("[TB] FAIL misalign_sticky: mis=%b addr=%h want 1 3004", misalign_err, imem_addr);
        end
        do_reset();
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_clear: got %b want 0", misalign_err);
        end
    endtask

    task automatic test_back_to_back();
        ifid_t e;
        is_branch = 1'b1; branch_taken = 1'b1; branch_target = 64'h4000;
        sb.push_back('{pc: 64'h0, instr: NOP, valid: 1'b0});
        tick();
        e = sb.pop_front();
        branch_target = 64'h5000;
        sb.push_back('{pc: 64'h0, instr: NOP, valid: 1'b0});
        tick();
        is_branch = 1'b0; branch_taken = 1'b0;
        e = sb.pop_front();
        checks++;
        if (imem_addr !== 64'h5000 || ifid_valid !== e.valid || ifid_instr !== e.instr || ifid_pc !== e.pc) begin
            errors++;
            $display("[TB] FAIL b2b_second: addr=%h ifid=%h/%h/%b want 5000 %h/%h/%b",
                     imem_addr, ifid_pc, ifid_instr, ifid_valid, e.pc, e.instr, e.valid);
        end
        imem_rdata = words[0];
        sb.push_back('{pc: 64'h5000, instr: words[0], valid: 1'b1});
        tick();
        e = sb.pop_front();
        checks++;
        if (ifid_pc !== e.pc || ifid_instr !== e.instr || ifid_valid !== e.valid) begin
            errors++;
            $display("[TB] FAIL b2b_target: got %h/%h/%b want %h/%h/%b",
                     ifid_pc, ifid_instr, ifid_valid, e.pc, e.instr, e.valid);
        end
    endtask

    task automatic test_reset_priority();
        stall = 1'b1; is_branch = 1'b1; branch_taken = 1'b1; branch_target = 64'h9000;
        do_reset();
        stall = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        checks++;
        if (imem_addr !== RST_PC || ifid_valid !== 1'b0 || branch_count !== 32'h0 || taken_count !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_priority: addr=%h valid=%b bc=%0d tc=%0d want %h 0 0 0",
                     imem_addr, ifid_valid, branch_count, taken_count, RST_PC);
        end
    endtask

    task automatic test_wrap();
        is_branch = 1'b1; branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        is_branch = 1'b0; branch_taken = 1'b0;
        imem_rdata = words[1];
        tick();
        checks++;
        if (imem_addr !== 64'h0 || ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ifid_instr !== words[1]) begin
            errors++;
            $display("[TB] FAIL pc_wrap: addr=%h ifid_pc=%h instr=%h want 0 fffffffffffffffc %h",
                     imem_addr, ifid_pc, ifid_instr, words[1]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.takenCount_q = 32'hFFFF_FFFF;
        #1;
        release dut.takenCount_q;
        is_branch = 1'b1; branch_taken = 1'b1; branch_target = 64'h6000;
        tick();
        is_branch = 1'b0; branch_taken = 1'b0;
        checks++;
        if (taken_count !== 32'hFFFF_FFFF || branch_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL taken_saturate: tc=%h bc=%0d want ffffffff 1", taken_count, branch_count);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        words[0] = 32'hA000_0A0A;
        words[1] = 32'hB000_0B0B;
        words[2] = 32'hC000_0C0C;
        words[3] = 32'hD000_0D0D;
        #2;
        test_reset();
        test_fetch();
        test_stall();
        test_taken_branch();
        test_not_taken();
        test_misalign();
        test_back_to_back();
        test_reset_priority();
        test_wrap();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
